// File: rtl/matrix_elem_sender.sv
// matrix_elem_sender: converts one signed matrix element, matrix ID or bare
// line break into ASCII bytes and hands them to the UART TX one at a time.
module matrix_elem_sender #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              is_last_col,
  input  logic              newline_only,
  input  logic              is_id,
  output logic              ready,
  output logic              done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done
);

  localparam int unsigned BUF_D  = MAX_DIGITS + 4;
  localparam int unsigned IDX_W  = $clog2(BUF_D + 1);
  localparam int unsigned PIDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned POW_W  = 64;

  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONV, S_SEP, S_EMIT, S_WAIT_TX, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_data;
  logic              r_last_col;
  logic              r_nl;
  logic              r_id;
  logic [DATA_W-1:0] r_mag;
  logic [PIDX_W-1:0] r_pow_idx;
  logic [3:0]        r_count;
  logic              r_started;
  logic [7:0]        r_buf [BUF_D];
  logic [IDX_W-1:0]  r_len;
  logic [IDX_W-1:0]  r_idx;

  logic              r_ready;
  logic              r_done;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;

  logic              w_ready_nxt;
  logic              w_done_nxt;
  logic              w_tx_start_nxt;
  logic [7:0]        w_tx_data_nxt;

  logic [POW_W-1:0]  w_pow;
  logic              w_ge;
  logic [3:0]        w_count_inc;
  logic              w_digit_done;
  logic [3:0]        w_digit;
  logic              w_last_digit;
  logic              w_emit_digit;
  logic              w_idx_last;
  logic              w_neg;

  // 10^k for the current digit position
  function automatic logic [POW_W-1:0] pow10(input logic [PIDX_W-1:0] k);
    logic [POW_W-1:0] p;
    p = POW_W'(1);
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < 32'(k)) p = p * POW_W'(10);
    end
    return p;
  endfunction

  // Digit conversion helpers; a count of 9 finishes a digit without another compare
  always_comb begin
    w_pow        = pow10(r_pow_idx);
    w_ge         = (POW_W'(r_mag) >= w_pow);
    w_count_inc  = 4'(r_count + 4'd1);
    w_digit_done = !w_ge || (r_count == 4'd8);
    w_digit      = w_ge ? w_count_inc : r_count;
    w_last_digit = (r_pow_idx == '0);
    w_emit_digit = w_digit_done && ((w_digit != 4'd0) || r_started || w_last_digit);
    w_idx_last   = (r_idx == IDX_W'(r_len - IDX_W'(1)));
    w_neg        = r_data[DATA_W-1];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    w_next = r_nl ? S_SEP : S_CONV;
      S_CONV:    if (w_digit_done && w_last_digit) w_next = S_SEP;
      S_SEP:     w_next = S_EMIT;
      S_EMIT:    w_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_done) w_next = w_idx_last ? S_DONE : S_EMIT;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state; byte 0 is still being written when leaving SEP
  always_comb begin
    w_ready_nxt    = (w_next == S_IDLE);
    w_done_nxt     = (w_next == S_DONE);
    w_tx_start_nxt = (w_next == S_EMIT);
    w_tx_data_nxt  = r_tx_data;
    if (w_next == S_EMIT) begin
      if (r_state == S_SEP) w_tx_data_nxt = (r_len == '0) ? CH_CR : r_buf[0];
      else                  w_tx_data_nxt = r_buf[IDX_W'(r_idx + IDX_W'(1))];
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_ready    <= w_ready_nxt;
      r_done     <= w_done_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // Request latch, magnitude reduction and byte buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_last_col <= 1'b0;
      r_nl       <= 1'b0;
      r_id       <= 1'b0;
      r_mag      <= '0;
      r_pow_idx  <= '0;
      r_count    <= '0;
      r_started  <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      for (int i = 0; i < int'(BUF_D); i++) r_buf[i] <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_data     <= data;
            r_last_col <= is_last_col;
            r_nl       <= newline_only;
            r_id       <= is_id;
          end
        end
        S_LOAD: begin
          r_pow_idx <= PIDX_W'(MAX_DIGITS - 1);
          r_count   <= '0;
          r_started <= 1'b0;
          r_mag     <= w_neg ? DATA_W'(~r_data + DATA_W'(1)) : r_data;
          if (r_id && !r_nl) begin
            r_buf[0] <= CH_HASH;
            if (w_neg && !r_nl) begin
              r_buf[1] <= CH_MINUS;
              r_len    <= IDX_W'(2);
            end else begin
              r_len    <= IDX_W'(1);
            end
          end else if (w_neg && !r_nl) begin
            r_buf[0] <= CH_MINUS;
            r_len    <= IDX_W'(1);
          end else begin
            r_len    <= '0;
          end
        end
        S_CONV: begin
          if (w_ge) begin
            r_mag   <= DATA_W'(POW_W'(r_mag) - w_pow);
            r_count <= w_count_inc;
          end
          if (w_digit_done) begin
            r_count <= '0;
            if (w_emit_digit) begin
              r_buf[r_len] <= 8'(CH_ZERO + 8'(w_digit));
              r_len        <= IDX_W'(r_len + IDX_W'(1));
              r_started    <= 1'b1;
            end
            if (!w_last_digit) r_pow_idx <= PIDX_W'(r_pow_idx - PIDX_W'(1));
          end
        end
        S_SEP: begin
          r_idx <= '0;
          if (r_last_col || r_nl) begin
            r_buf[r_len]                     <= CH_CR;
            r_buf[IDX_W'(r_len + IDX_W'(1))] <= CH_LF;
            r_len                            <= IDX_W'(r_len + IDX_W'(2));
          end else begin
            r_buf[r_len] <= CH_SPACE;
            r_len        <= IDX_W'(r_len + IDX_W'(1));
          end
        end
        S_WAIT_TX: begin
          if (tx_done && !w_idx_last) r_idx <= IDX_W'(r_idx + IDX_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_matrix_elem_sender.sv
// Directed bench for matrix_elem_sender with a UART TX responder model.
module tb_matrix_elem_sender;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] data;
  logic        is_last_col;
  logic        newline_only;
  logic        is_id;
  logic        ready;
  logic        done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  int          first_cyc = 0;
  int          n_done   = 0;
  int          overlap  = 0;
  int          rand_mode = 0;
  int          fixed_delay = 3;
  bit          busy = 0;
  int          cnt  = 0;
  logic [7:0]  q [$];

  matrix_elem_sender #(.DATA_W(32), .MAX_DIGITS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data         (data),
    .is_last_col  (is_last_col),
    .newline_only (newline_only),
    .is_id        (is_id),
    .ready        (ready),
    .done         (done),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_done      (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // TX responder and byte/done monitor, sampled on the falling edge
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          tx_done = 1'b1;
          busy    = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (rst_n && tx_start) begin
        if (q.size() == 0) first_cyc = cyc;
        q.push_back(tx_data);
        if (busy) overlap++;
        busy = 1'b1;
        cnt  = (rand_mode != 0) ? int'($urandom_range(50, 1)) : fixed_delay;
      end
      if (rst_n && done) n_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit lc, input bit nl, input bit id);
    q.delete();
    n_done  = 0;
    overlap = 0;
    @(negedge clk);
    data         = d;
    is_last_col  = lc;
    newline_only = nl;
    is_id        = id;
    start        = 1'b1;
    t_start      = cyc;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  task automatic check_stream(input string tag, input string exp);
    chk({tag, "_n_done"}, 32'(n_done), 32'd1);
    chk({tag, "_len"}, 32'(q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(q[i]), 32'(exp[i]));
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (q.size() >= n) ok = 1'b1;
    end
    chk({tag, "_bytes_reached"}, 32'(ok), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data = '0;
    is_last_col = 1'b0; newline_only = 1'b0; is_id = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero prints a single '0'
    send(32'sd0, 1'b0, 1'b0, 1'b0);
    chk("zero_ready_drop", 32'(ready), 32'd0);
    wait_done("zero");
    check_stream("zero", "0 ");

    send(-32'sd127, 1'b1, 1'b0, 1'b0);
    wait_done("m127");
    check_stream("m127", "-127\015\012");

    // most negative value and start-to-first-byte bound
    send(32'h8000_0000, 1'b0, 1'b0, 1'b0);
    wait_done("min");
    check_stream("min", "-2147483648 ");
    chk("min_latency_ok", 32'((first_cyc - t_start) <= 93), 32'd1);

    send(32'sd1000000000, 1'b1, 1'b0, 1'b0);
    wait_done("1e9");
    check_stream("1e9", "1000000000\015\012");

    send(32'sd3, 1'b1, 1'b0, 1'b1);
    wait_done("id3");
    check_stream("id3", "#3\015\012");

    send(32'sd99, 1'b0, 1'b1, 1'b0);
    wait_done("nl");
    check_stream("nl", "\015\012");

    send(-32'sd5, 1'b0, 1'b1, 1'b1);
    wait_done("nl_id");
    check_stream("nl_id", "\015\012");

    // random TX delays, mid-request start and input changes are ignored
    rand_mode = 1;
    send(32'sd2147483647, 1'b0, 1'b0, 1'b0);
    wait_done("max");
    check_stream("max", "2147483647 ");

    send(-32'sd127, 1'b1, 1'b0, 1'b0);
    wait_bytes("mid", 1);
    data = 32'sd555; is_id = 1'b1; is_last_col = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid");
    check_stream("mid", "-127\015\012");
    repeat (100) @(negedge clk);
    chk("mid_no_extra_bytes", 32'(q.size()), 32'd6);
    chk("mid_still_ready", 32'(ready), 32'd1);

    // reset while waiting for tx_done of the third byte
    rand_mode   = 0;
    fixed_delay = 20;
    send(32'sd1234, 1'b0, 1'b0, 1'b0);
    wait_bytes("rst", 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_tx_start", 32'(tx_start), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'h00);
    chk("rst_mid_done", 32'(done), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_no_tx_after", 32'(q.size()), 32'd0);
    chk("rst_no_done_after", 32'(n_done), 32'd0);
    chk("rst_ready_after", 32'(ready), 32'd1);

    fixed_delay = 2;
    send(32'sd5, 1'b0, 1'b0, 1'b0);
    wait_done("post_rst");
    check_stream("post_rst", "5 ");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
